convolution_sequencer: RTL and testbench
========================================

# convolution_sequencer

Controller that sequences one `convolution_layer` instance through a full frame: loads and holds the kernel, paces matrix rows into the layer one enabled clock at a time, and gates its output stream into a valid/ready interface with row indices. Sits between the upstream kernel/row sources and the layer. It is the only driver of the layer's `enable`, `kernel_input_stream` and `matrix_input_stream`.

## Interface
- `data_size`, 4, bits per element
- `max_input_matrix_width`, 9, elements per matrix row
- `max_kernel_width`, 3, elements per kernel row (K_W)
- `max_kernel_height`, 3, kernel rows (K)
- `matrix_height`, 9, matrix rows per frame (H, must be ≥ K); output rows R = H−K+1; OW = max_input_matrix_width−K_W+1
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle frame start request, honoured only in IDLE
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at end of frame
- `kernel_data`  in  data_size*K_W  kernel row, element 0 in the MSBs
- `kernel_valid` / `kernel_ready`  in / out  1  kernel-row handshake
- `row_data`  in  data_size*max_input_matrix_width  matrix row
- `row_valid` / `row_ready`  in / out  1  matrix-row handshake
- `out_data`  out  data_size*OW  convolution output row
- `out_row`  out  clog2(R) (min 1)  index of `out_data`, 0..R−1
- `out_valid` / `out_ready`  out / in  1  output handshake
- `conv_enable`  out  1  to layer `enable`
- `conv_kernel_stream`  out  data_size*K_W  to layer `kernel_input_stream`
- `conv_matrix_stream`  out  data_size*max_input_matrix_width  to layer `matrix_input_stream`
- `conv_output_stream`  in  data_size*OW  from layer `matrix_output_stream`
- `conv_buffer_full`  in  1  from layer `is_buffer_full`

## Operation
- Layer contract: samples both streams on each rising edge with `enable`=1. Its kernel and matrix buffers shift together. `is_buffer_full` and a valid `matrix_output_stream` follow the K-th enabled edge.
- FSM: IDLE → (start) LOAD_KERNEL → (K kernel beats) STREAM → (H rows accepted) DRAIN → (last output accepted) DONE → IDLE.
- LOAD_KERNEL: `kernel_ready`=1. Each beat writes kernel store entry 0..K−1. `conv_enable` stays 0.
- STREAM: `row_ready` = no row in flight AND `out_valid`=0. An accepted row i (0..H−1) registers `conv_matrix_stream`=row_data and `conv_kernel_stream`=kernel store[i mod K], and drives `conv_enable`=1 for exactly the next cycle.
- Capture: in the cycle after an enabled layer edge, if `conv_buffer_full`=1 and i ≥ K−1, the block latches `out_data`=conv_output_stream and `out_row`=i−(K−1), and sets `out_valid`. Rows 0..K−2 produce no output.
- `out_valid` holds with stable data until `out_ready`. No output is dropped or duplicated.
- DONE: `done`=1 for one cycle. The kernel store is retained but reloaded on every start.
- `start` outside IDLE is ignored. `kernel_valid`/`row_valid` outside their phase are not acknowledged.

## Timing
- Reset values: `busy`,`done`,`kernel_ready`,`row_ready`,`out_valid`,`conv_enable`=0. `out_data`,`out_row`,`conv_*_stream`, kernel store and counters are all 0. State is IDLE.
- The FSM leaves IDLE the cycle after `start`. `kernel_ready` rises that cycle.
- Row accepted at edge t: `conv_enable`=1 during cycle t→t+1, layer samples at edge t+1, `out_valid` rises after edge t+2 (2-cycle accept-to-output latency). With `out_ready` tied 1, peak rate is 1 row per 3 cycles.
- `row_ready` falls the cycle after acceptance and stays 0 until the in-flight row has been captured or discarded, and `out_valid` is 0.
- The last row is accepted in STREAM, then DRAIN is entered. `done` follows the edge where `out_valid`&&`out_ready` for `out_row`=R−1.
- Reset asserted mid-frame: all outputs clear immediately (asynchronously). The partial frame is lost, and the layer sees no further `enable`.
- Counters: the kernel counter wraps at K and the row counter saturates at H. There is no arithmetic on data.

## Structure
- Shared package `conv_pkg`: state encoding (IDLE, LOAD_KERNEL, STREAM, DRAIN, DONE), the OW/R derivation, and the `clog2` helper.
- One natural sub-module: `kernel_row_store`, a K-entry register file (write on load, read by index i mod K).

## Test plan
- K=3, H=9, kernel rows 1 2 3 / 4 5 6 / 7 8 9, matrix rows all 1, `out_ready`=1 → 7 outputs, `out_row` 0..6, each element 0x2D truncated to 4 bits (0xD). Exactly one `done` pulse, then `busy`=0.
- Same frame with `out_ready` low for 5 cycles at `out_row`=2 → `out_data`/`out_row` stable, `row_ready`=0 throughout, no output lost or repeated.
- `start` pulsed during STREAM → ignored; row and output counts unchanged.
- Row at index 1 accepted → `conv_enable` high exactly one cycle, `conv_kernel_stream` = kernel row 1; no `out_valid` for rows 0 and 1.
- `rst_n` low after 4 rows accepted → all outputs 0 within the reset cycle. A new frame after release then runs cleanly.
- H=K=3 → exactly one output with `out_row`=0, then `done`.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution sequencer: FSM encoding,
// output geometry derivation and a constant-safe clog2 helper.
package conv_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE        = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD_KERNEL = 3'd1;
    localparam logic [STATE_W-1:0] ST_STREAM      = 3'd2;
    localparam logic [STATE_W-1:0] ST_DRAIN       = 3'd3;
    localparam logic [STATE_W-1:0] ST_DONE        = 3'd4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_width(input int count);
        return (clog2(count) < 1) ? 1 : clog2(count);
    endfunction

    function automatic int out_width(input int matrix_w, input int kernel_w);
        return matrix_w - kernel_w + 1;
    endfunction

    function automatic int out_rows(input int height, input int kernel_h);
        return height - kernel_h + 1;
    endfunction

endpackage

// File: rtl/convolution_sequencer_kernel_row_store.sv
// K-entry kernel row register file: written during kernel load,
// read combinationally by row index modulo K while streaming.
module kernel_row_store
    import conv_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 3,
    parameter int IDX_W  = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_en && (wr_idx == IDX_W'(i))) mem_d[i] = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == IDX_W'(i)) rd_data = mem_q[i];
        end
    end

endmodule

// File: rtl/convolution_sequencer.sv
// Frame controller for one convolution_layer: loads the kernel, paces rows
// into the layer one enabled clock at a time and streams indexed output rows.
module convolution_sequencer
    import conv_pkg::*;
#(
    parameter int data_size              = 4,
    parameter int max_input_matrix_width = 9,
    parameter int max_kernel_width       = 3,
    parameter int max_kernel_height      = 3,
    parameter int matrix_height          = 9,
    localparam int KROW_W = data_size * max_kernel_width,
    localparam int MROW_W = data_size * max_input_matrix_width,
    localparam int OUT_W  = data_size * out_width(max_input_matrix_width, max_kernel_width),
    localparam int OROW_W = idx_width(out_rows(matrix_height, max_kernel_height))
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic [KROW_W-1:0] kernel_data,
    input  logic              kernel_valid,
    output logic              kernel_ready,
    input  logic [MROW_W-1:0] row_data,
    input  logic              row_valid,
    output logic              row_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic [OROW_W-1:0] out_row,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              conv_enable,
    output logic [KROW_W-1:0] conv_kernel_stream,
    output logic [MROW_W-1:0] conv_matrix_stream,
    input  logic [OUT_W-1:0]  conv_output_stream,
    input  logic              conv_buffer_full
);

    localparam int K      = max_kernel_height;
    localparam int H      = matrix_height;
    localparam int R      = out_rows(H, K);
    localparam int KIDX_W = idx_width(K);
    localparam int RCNT_W = idx_width(H + 1);

    // Handshakes: a beat transfers on the rising edge where valid && ready.
    // Every ready is a function of registered state only, never of valid.

    logic [STATE_W-1:0] state_q, state_d;
    logic [KIDX_W-1:0]  kcnt_q, kcnt_d;
    logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
    logic [RCNT_W-1:0]  row_idx_q, row_idx_d;
    logic               in_flight_q, in_flight_d;
    logic               conv_enable_q, conv_enable_d;
    logic [KROW_W-1:0]  conv_kernel_q, conv_kernel_d;
    logic [MROW_W-1:0]  conv_matrix_q, conv_matrix_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_data_q, out_data_d;
    logic [OROW_W-1:0]  out_row_q, out_row_d;

    logic               store_wr_en;
    logic [KROW_W-1:0]  store_rd_data;
    logic               capture_phase;
    logic               out_fire;

    kernel_row_store #(
        .DATA_W (KROW_W),
        .DEPTH  (K),
        .IDX_W  (KIDX_W)
    ) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (store_wr_en),
        .wr_idx  (kcnt_q),
        .wr_data (kernel_data),
        .rd_idx  (kcnt_q),
        .rd_data (store_rd_data)
    );

    // The layer sampled on the previous edge; its result is valid this cycle.
    assign capture_phase = in_flight_q && !conv_enable_q;
    assign out_fire      = out_valid_q && out_ready;

    always_comb begin
        state_d       = state_q;
        kcnt_d        = kcnt_q;
        rcnt_d        = rcnt_q;
        row_idx_d     = row_idx_q;
        in_flight_d   = in_flight_q;
        conv_enable_d = 1'b0;
        conv_kernel_d = conv_kernel_q;
        conv_matrix_d = conv_matrix_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        out_row_d     = out_row_q;
        store_wr_en   = 1'b0;
        kernel_ready  = (state_q == ST_LOAD_KERNEL);
        row_ready     = (state_q == ST_STREAM) && !in_flight_q && !out_valid_q;

        if (out_fire) out_valid_d = 1'b0;

        if (capture_phase) begin
            in_flight_d = 1'b0;
            if (conv_buffer_full && (row_idx_q >= RCNT_W'(K - 1))) begin
                out_valid_d = 1'b1;
                out_data_d  = conv_output_stream;
                out_row_d   = OROW_W'(row_idx_q - RCNT_W'(K - 1));
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_KERNEL;
                    kcnt_d  = '0;
                    rcnt_d  = '0;
                end
            end
            ST_LOAD_KERNEL: begin
                if (kernel_valid) begin
                    store_wr_en = 1'b1;
                    if (kcnt_q == KIDX_W'(K - 1)) begin
                        kcnt_d  = '0;
                        state_d = ST_STREAM;
                    end else begin
                        kcnt_d = kcnt_q + KIDX_W'(1);
                    end
                end
            end
            ST_STREAM: begin
                if (row_valid && row_ready) begin
                    conv_matrix_d = row_data;
                    conv_kernel_d = store_rd_data;
                    conv_enable_d = 1'b1;
                    in_flight_d   = 1'b1;
                    row_idx_d     = rcnt_q;
                    kcnt_d        = (kcnt_q == KIDX_W'(K - 1)) ? '0 : kcnt_q + KIDX_W'(1);
                    rcnt_d        = (rcnt_q == RCNT_W'(H)) ? rcnt_q : rcnt_q + RCNT_W'(1);
                    if (rcnt_q == RCNT_W'(H - 1)) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_fire && (out_row_q == OROW_W'(R - 1))) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            kcnt_q        <= '0;
            rcnt_q        <= '0;
            row_idx_q     <= '0;
            in_flight_q   <= 1'b0;
            conv_enable_q <= 1'b0;
            conv_kernel_q <= '0;
            conv_matrix_q <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_row_q     <= '0;
        end else begin
            state_q       <= state_d;
            kcnt_q        <= kcnt_d;
            rcnt_q        <= rcnt_d;
            row_idx_q     <= row_idx_d;
            in_flight_q   <= in_flight_d;
            conv_enable_q <= conv_enable_d;
            conv_kernel_q <= conv_kernel_d;
            conv_matrix_q <= conv_matrix_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
            out_row_q     <= out_row_d;
        end
    end

    assign busy               = (state_q != ST_IDLE);
    assign done               = (state_q == ST_DONE);
    assign conv_enable        = conv_enable_q;
    assign conv_kernel_stream = conv_kernel_q;
    assign conv_matrix_stream = conv_matrix_q;
    assign out_valid          = out_valid_q;
    assign out_data           = out_data_q;
    assign out_row            = out_row_q;

endmodule

// File: tb/tb_convolution_sequencer.sv
// Bench for convolution_sequencer: a behavioural layer model, a table of
// full frames with hand-computed outputs, and directed corner sequences.
module tb_convolution_sequencer;

    typedef struct {
        bit              ramp;
        logic [3:0]      mval;
        int              stall_row;
        int              stall_cyc;
        bit              glitch;
        logic [6:0][3:0] exp_nib;
    } frame_vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start, busy, done;
    logic [11:0] kernel_data;
    logic        kernel_valid, kernel_ready;
    logic [35:0] row_data;
    logic        row_valid, row_ready;
    logic [27:0] out_data;
    logic [2:0]  out_row;
    logic        out_valid, out_ready;
    logic        conv_enable;
    logic [11:0] conv_kernel_stream;
    logic [35:0] conv_matrix_stream;
    logic [27:0] conv_output_stream;
    logic        conv_buffer_full;

    logic        start3, busy3, done3;
    logic [11:0] kernel_data3;
    logic        kernel_valid3, kernel_ready3;
    logic [35:0] row_data3;
    logic        row_valid3, row_ready3;
    logic [27:0] out_data3;
    logic [0:0]  out_row3;
    logic        out_valid3, out_ready3;
    logic        conv_enable3;
    logic [11:0] conv_kernel_stream3;
    logic [35:0] conv_matrix_stream3;
    logic [27:0] conv_output_stream3;
    logic        conv_buffer_full3;

    convolution_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .kernel_data(kernel_data), .kernel_valid(kernel_valid), .kernel_ready(kernel_ready),
        .row_data(row_data), .row_valid(row_valid), .row_ready(row_ready),
        .out_data(out_data), .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
        .conv_enable(conv_enable), .conv_kernel_stream(conv_kernel_stream),
        .conv_matrix_stream(conv_matrix_stream), .conv_output_stream(conv_output_stream),
        .conv_buffer_full(conv_buffer_full)
    );

    convolution_sequencer #(.matrix_height(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
        .kernel_data(kernel_data3), .kernel_valid(kernel_valid3), .kernel_ready(kernel_ready3),
        .row_data(row_data3), .row_valid(row_valid3), .row_ready(row_ready3),
        .out_data(out_data3), .out_row(out_row3), .out_valid(out_valid3), .out_ready(out_ready3),
        .conv_enable(conv_enable3), .conv_kernel_stream(conv_kernel_stream3),
        .conv_matrix_stream(conv_matrix_stream3), .conv_output_stream(conv_output_stream3),
        .conv_buffer_full(conv_buffer_full3)
    );

    // Layer model: kernel and matrix rows shift together on enabled edges.
    function automatic logic [27:0] layer_out(input logic [2:0][11:0] k, input logic [2:0][35:0] m);
        logic [27:0] res;
        int acc;
        res = '0;
        for (int c = 0; c < 7; c++) begin
            acc = 0;
            for (int r = 0; r < 3; r++)
                for (int kc = 0; kc < 3; kc++)
                    acc += int'(k[r][(11 - 4 * kc) -: 4]) * int'(m[r][(35 - 4 * (c + kc)) -: 4]);
            res[(27 - 4 * c) -: 4] = acc[3:0];
        end
        return res;
    endfunction

    logic [2:0][11:0] lk, lk3;
    logic [2:0][35:0] lm, lm3;
    int lcnt, lcnt3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk <= '0; lm <= '0; lcnt <= 0;
        end else if (conv_enable) begin
            lk <= {lk[1:0], conv_kernel_stream};
            lm <= {lm[1:0], conv_matrix_stream};
            lcnt <= lcnt + 1;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lk3 <= '0; lm3 <= '0; lcnt3 <= 0;
        end else if (conv_enable3) begin
            lk3 <= {lk3[1:0], conv_kernel_stream3};
            lm3 <= {lm3[1:0], conv_matrix_stream3};
            lcnt3 <= lcnt3 + 1;
        end
    end

    assign conv_output_stream  = layer_out(lk, lm);
    assign conv_buffer_full    = (lcnt >= 3);
    assign conv_output_stream3 = layer_out(lk3, lm3);
    assign conv_buffer_full3   = (lcnt3 >= 3);

    int errors = 0;
    int checks = 0;
    logic [11:0] krow [3];
    frame_vec_t vecs [5];

    bit mon_on = 1'b0;
    int done_cnt, en_cnt, en_b2b;
    bit en_prev = 1'b0;

    always @(negedge clk) begin
        if (mon_on) begin
            if (done) done_cnt++;
            if (conv_enable) begin
                en_cnt++;
                if (en_prev) en_b2b++;
            end
        end
        en_prev = conv_enable;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    function automatic logic [35:0] rep9(input logic [3:0] n);
        return {9{n}};
    endfunction

    function automatic logic [27:0] rep7(input logic [3:0] n);
        return {7{n}};
    endfunction

    task automatic load_kernel();
        int w;
        for (int k = 0; k < 3; k++) begin
            kernel_data  = krow[k];
            kernel_valid = 1'b1;
            w = 0;
            while (!kernel_ready && w < 50) begin @(negedge clk); w++; end
            if (w >= 50) timeout_fail("kernel_beat");
            @(negedge clk);
        end
        kernel_valid = 1'b0;
        check("kernel_ready_after_load", 64'(kernel_ready), 64'd0);
    endtask

    task automatic accept_row(input logic [35:0] d);
        int w;
        row_data  = d;
        row_valid = 1'b1;
        w = 0;
        while (!row_ready && w < 100) begin @(negedge clk); w++; end
        if (w >= 100) timeout_fail("row_accept");
        @(negedge clk);
        row_valid = 1'b0;
    endtask

    task automatic drive_rows(input frame_vec_t v);
        for (int i = 0; i < 9; i++) begin
            if (v.glitch && i == 4) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            accept_row(v.ramp ? rep9(4'(i + 1)) : rep9(v.mval));
        end
    endtask

    task automatic consume(input frame_vec_t v);
        int got, cyc;
        bit stalled;
        got = 0; cyc = 0; stalled = 1'b0;
        out_ready = 1'b1;
        while (got < 7 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (!stalled && v.stall_row >= 0 && int'(out_row) == v.stall_row) begin
                    out_ready = 1'b0;
                    for (int s = 0; s < v.stall_cyc; s++) begin
                        @(negedge clk);
                        check("stall_valid", 64'(out_valid), 64'd1);
                        check("stall_row", 64'(out_row), 64'(v.stall_row));
                        check("stall_data", 64'(out_data), 64'(rep7(v.exp_nib[v.stall_row])));
                        check("stall_row_ready", 64'(row_ready), 64'd0);
                    end
                    stalled   = 1'b1;
                    out_ready = 1'b1;
                end
                check("out_row", 64'(out_row), 64'(got));
                check("out_data", 64'(out_data), 64'(rep7(v.exp_nib[got])));
                got++;
            end
        end
        check("out_count", 64'(got), 64'd7);
    endtask

    task automatic run_frame(input frame_vec_t v);
        done_cnt = 0; en_cnt = 0; en_b2b = 0;
        mon_on = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        check("kernel_ready_after_start", 64'(kernel_ready), 64'd1);
        load_kernel();
        fork
            drive_rows(v);
            consume(v);
        join
        repeat (3) @(negedge clk);
        mon_on = 1'b0;
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("busy_end", 64'(busy), 64'd0);
        check("enable_cycles", 64'(en_cnt), 64'd9);
        check("enable_back_to_back", 64'(en_b2b), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_kernel_ready"}, 64'(kernel_ready), 64'd0);
        check({tag, "_row_ready"}, 64'(row_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_conv_enable"}, 64'(conv_enable), 64'd0);
        check({tag, "_out_data"}, 64'(out_data), 64'd0);
        check({tag, "_out_row"}, 64'(out_row), 64'd0);
        check({tag, "_conv_kernel"}, 64'(conv_kernel_stream), 64'd0);
        check({tag, "_conv_matrix"}, 64'(conv_matrix_stream), 64'd0);
    endtask

    int outs3, dones3, cyc3, w3;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        krow[0] = 12'h123;
        krow[1] = 12'h456;
        krow[2] = 12'h789;
        // Uniform rows m give 45*m per element; ramp rows hold row_index+1.
        vecs[0] = '{ramp: 1'b0, mval: 4'h1, stall_row: -1, stall_cyc: 0, glitch: 1'b0, exp_nib: {7{4'hD}}};
        vecs[1] = '{ramp: 1'b0, mval: 4'h1, stall_row: 2, stall_cyc: 5, glitch: 1'b0, exp_nib: {7{4'hD}}};
        vecs[2] = '{ramp: 1'b0, mval: 4'h2, stall_row: -1, stall_cyc: 0, glitch: 1'b1, exp_nib: {7{4'hA}}};
        vecs[3] = '{ramp: 1'b1, mval: 4'h0, stall_row: -1, stall_cyc: 0, glitch: 1'b0,
                    exp_nib: {4'hA, 4'h2, 4'h5, 4'h3, 4'hB, 4'hE, 4'hC}};
        vecs[4] = '{ramp: 1'b0, mval: 4'h3, stall_row: 6, stall_cyc: 3, glitch: 1'b0, exp_nib: {7{4'h7}}};

        start = 0; kernel_data = '0; kernel_valid = 0; row_data = '0; row_valid = 0; out_ready = 0;
        start3 = 0; kernel_data3 = '0; kernel_valid3 = 0; row_data3 = '0; row_valid3 = 0; out_ready3 = 0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        kernel_valid = 1'b1;
        row_valid    = 1'b1;
        @(negedge clk);
        check("idle_kernel_ready", 64'(kernel_ready), 64'd0);
        check("idle_row_ready", 64'(row_ready), 64'd0);
        check("idle_busy", 64'(busy), 64'd0);
        kernel_valid = 1'b0;
        row_valid    = 1'b0;

        for (int t = 0; t < 5; t++) run_frame(vecs[t]);

        // Row pacing detail, accept-to-output latency, then reset mid-frame.
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        load_kernel();
        accept_row(rep9(4'h1));
        check("row0_enable", 64'(conv_enable), 64'd1);
        check("row0_kernel", 64'(conv_kernel_stream), 64'(krow[0]));
        accept_row(rep9(4'h2));
        check("row1_enable", 64'(conv_enable), 64'd1);
        check("row1_kernel", 64'(conv_kernel_stream), 64'(krow[1]));
        check("row1_matrix", 64'(conv_matrix_stream), 64'(rep9(4'h2)));
        check("row1_row_ready", 64'(row_ready), 64'd0);
        @(negedge clk);
        check("row1_enable_off", 64'(conv_enable), 64'd0);
        check("row1_no_valid_a", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("row1_no_valid_b", 64'(out_valid), 64'd0);
        accept_row(rep9(4'h3));
        check("row2_valid_t1", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("row2_valid_t2", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("row2_valid_t3", 64'(out_valid), 64'd1);
        check("row2_out_row", 64'(out_row), 64'd0);
        check("row2_out_data", 64'(out_data), 64'(rep7(4'hC)));
        accept_row(rep9(4'h4));
        check("row3_enable", 64'(conv_enable), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(negedge clk);
        check("midreset_enable_held", 64'(conv_enable), 64'd0);
        rst_n = 1'b1;
        run_frame(vecs[3]);

        // Degenerate frame: matrix height equals kernel height.
        outs3 = 0; dones3 = 0; cyc3 = 0;
        out_ready3 = 1'b1;
        @(negedge clk);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        check("h3_busy", 64'(busy3), 64'd1);
        for (int k = 0; k < 3; k++) begin
            kernel_data3  = krow[k];
            kernel_valid3 = 1'b1;
            w3 = 0;
            while (!kernel_ready3 && w3 < 50) begin @(negedge clk); w3++; end
            if (w3 >= 50) timeout_fail("h3_kernel_beat");
            @(negedge clk);
        end
        kernel_valid3 = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    row_data3  = rep9(4'h1);
                    row_valid3 = 1'b1;
                    w3 = 0;
                    while (!row_ready3 && w3 < 50) begin @(negedge clk); w3++; end
                    if (w3 >= 50) timeout_fail("h3_row_accept");
                    @(negedge clk);
                end
                row_valid3 = 1'b0;
            end
            begin
                while (cyc3 < 80 && !(dones3 > 0 && !busy3)) begin
                    @(negedge clk);
                    cyc3++;
                    if (done3) dones3++;
                    if (out_valid3) begin
                        outs3++;
                        check("h3_out_row", 64'(out_row3), 64'd0);
                        check("h3_out_data", 64'(out_data3), 64'(rep7(4'hD)));
                    end
                end
            end
        join
        check("h3_out_count", 64'(outs3), 64'd1);
        check("h3_done_pulses", 64'(dones3), 64'd1);
        check("h3_busy_end", 64'(busy3), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
